// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle for stream_rr_arbiter: N upstream valid/ready requesters
// and one downstream valid/yumi consumer.
interface stream_rr_arbiter_if #(
    parameter int width_p   = 8,
    parameter int num_req_p = 2
);
    localparam int id_width_lp = $clog2(num_req_p);

    logic [num_req_p*width_p-1:0] data_i;
    logic [num_req_p-1:0]         last_i;
    logic [num_req_p-1:0]         valid_i;
    logic [num_req_p-1:0]         ready_o;
    logic                         valid_o;
    logic [width_p-1:0]           data_o;
    logic                         last_o;
    logic [id_width_lp-1:0]       id_o;
    logic                         yumi_i;
    logic                         locked_o;

    modport slave (
        input  data_i, last_i, valid_i, yumi_i,
        output ready_o, valid_o, data_o, last_o, id_o, locked_o
    );

    modport master (
        output data_i, last_i, valid_i, yumi_i,
        input  ready_o, valid_o, data_o, last_o, id_o, locked_o
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter feeding one registered elastic output stage.
// A winner keeps the grant until its last beat is accepted.
module stream_rr_arbiter #(
    parameter int width_p   = 8,
    parameter int num_req_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    stream_rr_arbiter_if.slave io
);
    localparam int id_width_lp = $clog2(num_req_p);
    localparam logic [id_width_lp-1:0] last_idx_lp =
        id_width_lp'(num_req_p - 1);
    localparam logic [id_width_lp:0] num_lp =
        (id_width_lp + 1)'(num_req_p);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e                 state_q, state_d;
    logic [id_width_lp-1:0] ptr_q, ptr_d;
    logic [id_width_lp-1:0] owner_q, owner_d;
    logic [id_width_lp-1:0] id_q, id_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [width_p-1:0]     data_q, data_d;

    logic [id_width_lp-1:0] grant_w;
    logic [id_width_lp-1:0] sel_w;
    logic [id_width_lp:0]   slot_w;
    logic                   grant_found_w;
    logic                   sel_ok_w;
    logic                   accept_w;
    logic                   xfer_w;
    logic [num_req_p-1:0]   ready_w;

    // Rotating-priority search: first valid requester at or after ptr_q.
    always_comb begin
        grant_w       = '0;
        grant_found_w = 1'b0;
        slot_w        = '0;
        for (int j = 0; j < num_req_p; j++) begin
            slot_w = {1'b0, ptr_q} + (id_width_lp + 1)'(j);
            if (slot_w >= num_lp) begin
                slot_w = slot_w - num_lp;
            end
            if (!grant_found_w && io.valid_i[slot_w[id_width_lp-1:0]]) begin
                grant_found_w = 1'b1;
                grant_w       = slot_w[id_width_lp-1:0];
            end
        end
    end

    always_comb begin
        accept_w = ~valid_q | io.yumi_i;
        sel_w    = (state_q == LOCKED) ? owner_q : grant_w;
        sel_ok_w = (state_q == LOCKED) | grant_found_w;
        ready_w  = '0;
        if (sel_ok_w) begin
            ready_w[sel_w] = accept_w;
        end
        xfer_w = |(ready_w & io.valid_i);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        id_d    = id_q;
        if (xfer_w) begin
            valid_d = 1'b1;
            data_d  = io.data_i[int'(sel_w)*width_p +: width_p];
            last_d  = io.last_i[sel_w];
            id_d    = sel_w;
            if (io.last_i[sel_w]) begin
                state_d = IDLE;
                ptr_d   = (sel_w == last_idx_lp) ? '0 : sel_w + 1'b1;
            end else begin
                state_d = LOCKED;
                owner_d = sel_w;
            end
        end else if (io.yumi_i) begin
            // Drain without refill: payload stays, only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end

    assign io.ready_o  = ready_w;
    assign io.valid_o  = valid_q;
    assign io.data_o   = data_q;
    assign io.last_o   = last_q;
    assign io.id_o     = id_q;
    assign io.locked_o = (state_q == LOCKED);
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: a 2-requester and a 3-requester
// instance, each checked every cycle against a packet-level model.
module tb_stream_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    int       nreq [2] = '{2, 3};
    bit [2:0] vi   [2];
    bit [2:0] li   [2];
    bit [7:0] di   [2][3];
    bit       yu   [2];

    stream_rr_arbiter_if #(.width_p(8), .num_req_p(2)) i2 ();
    stream_rr_arbiter_if #(.width_p(8), .num_req_p(3)) i3 ();

    assign i2.valid_i = vi[0][1:0];
    assign i2.last_i  = li[0][1:0];
    assign i2.data_i  = {di[0][1], di[0][0]};
    assign i2.yumi_i  = yu[0];
    assign i3.valid_i = vi[1];
    assign i3.last_i  = li[1];
    assign i3.data_i  = {di[1][2], di[1][1], di[1][0]};
    assign i3.yumi_i  = yu[1];

    stream_rr_arbiter #(.width_p(8), .num_req_p(2)) u2 (
        .clk_i  (clk),
        .reset_i(rst),
        .io     (i2)
    );

    stream_rr_arbiter #(.width_p(8), .num_req_p(3)) u3 (
        .clk_i  (clk),
        .reset_i(rst),
        .io     (i3)
    );

    // Model state: output register contents, lock owner, next-priority slot.
    bit       mv  [2];
    bit [7:0] md  [2];
    bit       ml  [2];
    int       mid [2];
    bit       mlk [2];
    int       mptr[2];
    int       mown[2];

    function automatic int grant(int k);
        if (mlk[k]) return mown[k];
        for (int j = 0; j < nreq[k]; j++) begin
            int r;
            r = (mptr[k] + j) % nreq[k];
            if (vi[k][r]) return r;
        end
        return -1;
    endfunction

    function automatic bit [2:0] exp_ready(int k);
        int g;
        bit [2:0] r;
        g = grant(k);
        r = '0;
        if (g >= 0 && (!mv[k] || yu[k])) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mv[k] = 0; md[k] = 0; ml[k] = 0; mid[k] = 0;
                mlk[k] = 0; mptr[k] = 0; mown[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int g;
                bit [2:0] r;
                g = grant(k);
                r = exp_ready(k);
                if (g >= 0 && r[g] && vi[k][g]) begin
                    mv[k] = 1;
                    md[k] = di[k][g];
                    ml[k] = li[k][g];
                    mid[k] = g;
                    if (li[k][g]) begin
                        mlk[k] = 0;
                        mptr[k] = (g + 1) % nreq[k];
                    end else begin
                        mlk[k] = 1;
                        mown[k] = g;
                    end
                end else if (yu[k]) begin
                    mv[k] = 0;
                end
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(int k, bit v, bit [7:0] d, bit l, int id,
                       bit lk, bit [2:0] rdy);
        string p;
        p = $sformatf("n%0d@%0t", nreq[k], $time);
        chk({p, " valid_o"}, v, mv[k]);
        chk({p, " data_o"}, d, md[k]);
        chk({p, " last_o"}, l, ml[k]);
        chk({p, " id_o"}, id, mid[k]);
        chk({p, " locked_o"}, lk, mlk[k]);
        chk({p, " ready_o"}, rdy, exp_ready(k));
        chk({p, " yumi_proto"}, int'(yu[k] && !v), 0);
    endtask

    always @(negedge clk) begin
        cmp(0, i2.valid_o, i2.data_o, i2.last_o, int'(i2.id_o),
            i2.locked_o, {1'b0, i2.ready_o});
        cmp(1, i3.valid_o, i3.data_o, i3.last_o, int'(i3.id_o),
            i3.locked_o, i3.ready_o);
    end

    task automatic drv(int k, bit [2:0] v, bit [2:0] l,
                       bit [7:0] d0, bit [7:0] d1, bit [7:0] d2, bit y);
        vi[k] = v;
        li[k] = l;
        di[k][0] = d0;
        di[k][1] = d1;
        di[k][2] = d2;
        yu[k] = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat2(string nm, int id, int d);
        chk({nm, " valid"}, i2.valid_o, 1);
        chk({nm, " id"}, int'(i2.id_o), id);
        chk({nm, " data"}, i2.data_o, d);
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset between edges while holding a beat and locked
        drv(0, 3'b010, 3'b000, 0, 8'h77, 0, 0);
        tick();
        beat2("t1 pre", 1, 8'h77);
        chk("t1 pre locked", i2.locked_o, 1);
        rst = 1'b1;
        #1;
        chk("t1 rst valid", i2.valid_o, 0);
        chk("t1 rst locked", i2.locked_o, 0);
        chk("t1 rst id", int'(i2.id_o), 0);
        #1 rst = 1'b0;

        // Round-robin, single-beat packets, no bubbles
        drv(0, 3'b011, 3'b011, 8'h10, 8'h20, 0, 0);
        #1 chk("t1 ready after rst", int'(i2.ready_o), 1);
        tick();
        beat2("t2 b0", 0, 8'h10);
        drv(0, 3'b011, 3'b011, 8'h11, 8'h20, 0, 1);
        tick();
        beat2("t2 b1", 1, 8'h20);
        drv(0, 3'b011, 3'b011, 8'h11, 8'h21, 0, 1);
        tick();
        beat2("t2 b2", 0, 8'h11);
        drv(0, 3'b011, 3'b011, 8'h12, 8'h21, 0, 1);
        tick();
        beat2("t2 b3", 1, 8'h21);

        // Three-beat packet from requester 0 holds off requester 1
        drv(0, 3'b011, 3'b010, 8'hA1, 8'h20, 0, 1);
        #1 chk("t3 ready a1", int'(i2.ready_o), 1);
        tick();
        beat2("t3 a1", 0, 8'hA1);
        chk("t3 lock a1", i2.locked_o, 1);
        drv(0, 3'b011, 3'b010, 8'hA2, 8'h20, 0, 1);
        #1 chk("t3 ready a2", int'(i2.ready_o), 1);
        tick();
        beat2("t3 a2", 0, 8'hA2);
        chk("t3 lock a2", i2.locked_o, 1);
        drv(0, 3'b011, 3'b011, 8'hA3, 8'h20, 0, 1);
        #1 chk("t3 ready a3", int'(i2.ready_o), 1);
        tick();
        beat2("t3 a3", 0, 8'hA3);
        chk("t3 last a3", i2.last_o, 1);
        chk("t3 unlock", i2.locked_o, 0);
        drv(0, 3'b010, 3'b010, 0, 8'h20, 0, 1);
        #1 chk("t3 ready r1", int'(i2.ready_o), 2);
        tick();
        beat2("t3 r1", 1, 8'h20);

        // Backpressure: hold 0x55 for three cycles
        drv(0, 3'b001, 3'b001, 8'h55, 0, 0, 1);
        tick();
        beat2("t4 load", 0, 8'h55);
        for (int i = 0; i < 3; i++) begin
            drv(0, 3'b010, 3'b010, 0, 8'h66, 0, 0);
            #1 chk("t4 hold ready", int'(i2.ready_o), 0);
            tick();
            beat2("t4 hold", 0, 8'h55);
        end
        drv(0, 3'b010, 3'b010, 0, 8'h66, 0, 1);
        #1 chk("t4 yumi ready", int'(i2.ready_o), 2);
        tick();
        beat2("t4 next", 1, 8'h66);
        drv(0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("t4 drain valid", i2.valid_o, 0);
        chk("t4 drain data", i2.data_o, 8'h66);

        // Reset mid-packet with ptr pointing at requester 1
        drv(0, 3'b001, 3'b001, 8'h30, 0, 0, 0);
        tick();
        beat2("t6 single", 0, 8'h30);
        drv(0, 3'b010, 3'b000, 0, 8'h31, 0, 1);
        tick();
        beat2("t6 lock", 1, 8'h31);
        chk("t6 locked", i2.locked_o, 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("t6 rst locked", i2.locked_o, 0);
        chk("t6 rst valid", i2.valid_o, 0);
        #1 rst = 1'b0;
        drv(0, 3'b011, 3'b011, 8'h40, 8'h50, 0, 0);
        #1 chk("t6 ready", int'(i2.ready_o), 1);
        tick();
        beat2("t6 first", 0, 8'h40);
        drv(0, 0, 0, 0, 0, 0, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);

        // Wrap with three requesters
        drv(1, 3'b010, 3'b111, 0, 8'h71, 0, 0);
        tick();
        chk("t5 r1 id", int'(i3.id_o), 1);
        chk("t5 r1 data", i3.data_o, 8'h71);
        drv(1, 3'b101, 3'b111, 8'h80, 0, 8'h82, 1);
        #1 chk("t5 ready r2", int'(i3.ready_o), 4);
        tick();
        chk("t5 r2 id", int'(i3.id_o), 2);
        chk("t5 r2 data", i3.data_o, 8'h82);
        drv(1, 3'b101, 3'b111, 8'h80, 0, 8'h83, 1);
        #1 chk("t5 ready wrap", int'(i3.ready_o), 1);
        tick();
        chk("t5 r0 id", int'(i3.id_o), 0);
        chk("t5 r0 data", i3.data_o, 8'h80);
        chk("t5 r0 valid", i3.valid_o, 1);
        drv(1, 0, 0, 0, 0, 0, 1);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
